// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared FSM encoding and select-bus constants for the mux scanner
// Holds the state enum, the select width and the reserved select code.
package mux_scan_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;
    localparam int SEL_W = 5;
    localparam logic [SEL_W-1:0] SEL_RSVD = 5'd31;
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: snapshot valid/ready channel from the scanner to its consumer
// snap_valid/snap_data/chg_mask/chg_any flow master->slave, snap_ready slave->master.
interface mux_scan_ctrl_if #(
    parameter int NUM_INP = 31,
    parameter int DW = 2
);
    logic snap_valid;
    logic snap_ready;
    logic [NUM_INP*DW-1:0] snap_data;
    logic [NUM_INP-1:0] chg_mask;
    logic chg_any;
    modport master (
        output snap_valid, snap_data, chg_mask, chg_any,
        input  snap_ready
    );
    modport slave (
        input  snap_valid, snap_data, chg_mask, chg_any,
        output snap_ready
    );
endinterface

// File: rtl/mux_scan_chg.sv
// mux_scan_chg: previous-snapshot register plus per-channel change comparator
// clk, rst_n: clock and async active-low reset
// load: entry to HOLD, registers chg_mask from cur vs prev
// hs: snapshot handshake, loads prev from snap
// cur: snapshot being published; snap: snapshot currently held
// chg_mask: per-channel differs-from-previous flags
module mux_scan_chg #(
    parameter int NUM_INP = 31,
    parameter int DW = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic hs,
    input  logic [NUM_INP*DW-1:0] cur,
    input  logic [NUM_INP*DW-1:0] snap,
    output logic [NUM_INP-1:0] chg_mask
);
    logic [NUM_INP*DW-1:0] prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            chg_mask <= '0;
        end else begin
            if (hs) prev <= snap;
            if (load)
                for (int i = 0; i < NUM_INP; i++)
                    chg_mask[i] <= cur[i*DW +: DW] != prev[i*DW +: DW];
        end
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks the mux select over all channels and publishes a packed snapshot
// clk, rst_n: clock and async active-low reset
// start: scan request, honoured only in IDLE
// busy: high in SCAN and HOLD
// sel, mux_out: mux select driven out, mux data sampled back
// snap: master side of the snapshot valid/ready channel
// Optional change detection is built when MUX_SCAN_CHG_EN is defined.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int NUM_INP = 31,
    parameter int DW = 2,
    parameter int SETTLE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic [SEL_W-1:0] sel,
    input  logic [DW-1:0] mux_out,
    mux_scan_ctrl_if.master snap
);
    localparam int WW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
    localparam logic [WW-1:0] WMAX = WW'(SETTLE);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_INP - 1);
    localparam int SW = NUM_INP * DW;
    state_t state;
    logic [SEL_W-1:0] ch;
    logic [WW-1:0] wcnt;
    logic [SW-1:0] work;
    logic [SW-1:0] work_nxt;
    logic cap;
    logic done;
    // work with the current sample merged in, so HOLD entry publishes the last channel too
    always_comb begin
        work_nxt = work;
        work_nxt[int'(ch)*DW +: DW] = mux_out;
    end
    assign cap = state == SCAN && wcnt == WMAX;
    assign done = cap && ch == LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ch <= '0;
            wcnt <= '0;
            work <= '0;
            sel <= '0;
            busy <= 1'b0;
            snap.snap_valid <= 1'b0;
            snap.snap_data <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= SCAN;
                    ch <= '0;
                    wcnt <= '0;
                    sel <= '0;
                    busy <= 1'b1;
                end
                SCAN: if (!cap) wcnt <= wcnt + 1'b1;
                else begin
                    work <= work_nxt;
                    if (done) begin
                        state <= HOLD;
                        snap.snap_data <= work_nxt;
                        snap.snap_valid <= 1'b1;
                        sel <= '0;
                    end else begin
                        ch <= ch + 1'b1;
                        wcnt <= '0;
                        sel <= ch + 1'b1;
                    end
                end
                HOLD: if (snap.snap_ready) begin
                    state <= IDLE;
                    snap.snap_valid <= 1'b0;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef MUX_SCAN_CHG_EN
    logic hs;
    assign hs = snap.snap_valid && snap.snap_ready;
    mux_scan_chg #(.NUM_INP(NUM_INP), .DW(DW)) u_chg (
        .clk(clk),
        .rst_n(rst_n),
        .load(done),
        .hs(hs),
        .cur(work_nxt),
        .snap(snap.snap_data),
        .chg_mask(snap.chg_mask)
    );
    assign snap.chg_any = |snap.chg_mask;
`else
    assign snap.chg_mask = '0;
    assign snap.chg_any = 1'b0;
`endif
endmodule
